// File: rtl/ray_slice_sequencer_if.sv
// Frame request and ray-stream bundle between the sequencer and the slice-angle/ray-caster stages.
// The master modport is the sequencer side.
interface ray_slice_sequencer_if;
   logic       frame_start;
   logic [8:0] player_angle;
   logic       frame_busy;
   logic       frame_done;
   logic       ray_valid;
   logic       ray_ready;
   logic [7:0] slice_index;
   logic [8:0] ray_angle_int;
   logic [2:0] ray_angle_frac;
   logic       last_slice;

   modport master (
      input  frame_start, player_angle, ray_ready,
      output frame_busy, frame_done, ray_valid, slice_index,
             ray_angle_int, ray_angle_frac, last_slice
   );

   modport slave (
      output frame_start, player_angle, ray_ready,
      input  frame_busy, frame_done, ray_valid, slice_index,
             ray_angle_int, ray_angle_frac, last_slice
   );
endinterface

// File: rtl/ray_slice_sequencer.sv
// Per-frame ray sequencer: walks screen columns and emits one wrapped ray angle per column.
// Angles come from an accumulator kept in eighths of a degree, so no multiplier is needed.
module ray_slice_sequencer #(
   parameter int unsigned SLICES           = 160,
   parameter int unsigned HALF_FOV_EIGHTHS = 240,
   parameter int unsigned STEP_EIGHTHS     = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   ray_slice_sequencer_if.master io_ray
);
   localparam int unsigned ACC_W     = 12;
   localparam int unsigned IDX_W     = 8;
   localparam int unsigned FULL_TURN = 2880;

   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_slice, w_slice_nxt;
   logic [ACC_W-1:0]   r_acc, w_acc_nxt;
   logic               r_valid, w_valid_nxt;
   logic               r_last, w_last_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;

   logic [8:0]         w_heading;
   logic [ACC_W-1:0]   w_head8;
   logic [ACC_W-1:0]   w_start_acc;
   logic [ACC_W-1:0]   w_step_sum;
   logic [ACC_W-1:0]   w_step_acc;
   logic               w_xfer;

   // Start angle (heading - half FOV) and per-slice step, both wrapped into one turn
   always_comb begin
      w_heading   = (io_ray.player_angle < 9'd360) ? io_ray.player_angle
                                                   : io_ray.player_angle - 9'd360;
      w_head8     = {w_heading, 3'b000};
      w_start_acc = (w_head8 >= ACC_W'(HALF_FOV_EIGHTHS))
                  ? w_head8 - ACC_W'(HALF_FOV_EIGHTHS)
                  : w_head8 + ACC_W'(FULL_TURN - HALF_FOV_EIGHTHS);
      w_step_sum  = r_acc + ACC_W'(STEP_EIGHTHS);
      w_step_acc  = (w_step_sum >= ACC_W'(FULL_TURN)) ? w_step_sum - ACC_W'(FULL_TURN)
                                                      : w_step_sum;
      w_xfer      = r_valid & io_ray.ray_ready;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_slice_nxt = r_slice;
      w_acc_nxt   = r_acc;
      w_valid_nxt = r_valid;
      w_last_nxt  = r_last;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_ray.frame_start) begin
               w_state_nxt = S_EMIT;
               w_slice_nxt = '0;
               w_acc_nxt   = w_start_acc;
               w_valid_nxt = 1'b1;
               w_last_nxt  = (SLICES == 32'd1);
               w_busy_nxt  = 1'b1;
            end
         end
         S_EMIT: begin
            if (w_xfer) begin
               if (r_last) begin
                  w_state_nxt = S_DONE;
                  w_valid_nxt = 1'b0;
                  w_last_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_slice_nxt = r_slice + IDX_W'(1);
                  w_acc_nxt   = w_step_acc;
                  w_last_nxt  = (r_slice == IDX_W'(SLICES - 2));
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_slice <= '0;
         r_acc   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_slice <= w_slice_nxt;
         r_acc   <= w_acc_nxt;
         r_valid <= w_valid_nxt;
         r_last  <= w_last_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign io_ray.ray_valid      = r_valid;
   assign io_ray.slice_index    = r_slice;
   assign io_ray.ray_angle_int  = r_acc[ACC_W-1:3];
   assign io_ray.ray_angle_frac = r_acc[2:0];
   assign io_ray.last_slice     = r_last;
   assign io_ray.frame_busy     = r_busy;
   assign io_ray.frame_done     = r_done;
endmodule

// File: tb/tb_ray_slice_sequencer.sv
// Scoreboard bench for ray_slice_sequencer: stimulus queues expected rays, a negedge monitor checks transfers.
module tb_ray_slice_sequencer;
   typedef struct {
      int slice;
      int ai;
      int af;
      int last;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   n_done;
   int   exp_done;
   bit   pend_done;
   exp_t q[$];

   ray_slice_sequencer_if u_if ();

   ray_slice_sequencer u_dut (
      .clk    (clk),
      .reset  (reset),
      .io_ray (u_if.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int model_eighths(input int pa, input int s);
      int a;
      a = (pa < 360) ? pa : pa - 360;
      return ((a * 8 - 240 + s * 3) % 2880 + 2880) % 2880;
   endfunction

   // Monitor: pops one expectation per transfer and checks the done pulse that follows the last one
   always @(negedge clk) begin
      if (reset) begin
         pend_done = 1'b0;
      end else begin
         if (pend_done) begin
            check("done_after_last", int'(u_if.frame_done), 1);
            check("valid_in_done", int'(u_if.ray_valid), 0);
         end else if (u_if.frame_done) begin
            check("spurious_done", 1, 0);
         end
         if (u_if.frame_done) n_done++;
         pend_done = 1'b0;
         if (u_if.ray_valid && u_if.ray_ready) begin
            if (q.size() == 0) begin
               check("unexpected_ray", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("sb_slice", int'(u_if.slice_index), e.slice);
               check("sb_int", int'(u_if.ray_angle_int), e.ai);
               check("sb_frac", int'(u_if.ray_angle_frac), e.af);
               check("sb_last", int'(u_if.last_slice), e.last);
               if (e.last != 0) pend_done = 1'b1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input int pa);
      for (int s = 0; s < 160; s++) begin
         int e;
         e = model_eighths(pa, s);
         q.push_back('{s, e >> 3, e & 7, (s == 159) ? 1 : 0});
      end
   endtask

   task automatic start_frame(input int pa, input int ei, input int ef);
      u_if.player_angle = 9'(pa);
      u_if.frame_start  = 1'b1;
      tick();
      u_if.frame_start  = 1'b0;
      push_frame(pa);
      check("start_valid", int'(u_if.ray_valid), 1);
      check("start_busy", int'(u_if.frame_busy), 1);
      check("start_slice", int'(u_if.slice_index), 0);
      check("start_int", int'(u_if.ray_angle_int), ei);
      check("start_frac", int'(u_if.ray_angle_frac), ef);
      check("start_last", int'(u_if.last_slice), 0);
   endtask

   task automatic wait_slice(input int k, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (u_if.ray_valid && int'(u_if.slice_index) == k) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) check("slice_timeout", k, -1);
   endtask

   task automatic spot(input int k, input int ei, input int ef, input int el);
      bit ok;
      wait_slice(k, ok);
      if (ok) begin
         check("spot_int", int'(u_if.ray_angle_int), ei);
         check("spot_frac", int'(u_if.ray_angle_frac), ef);
         check("spot_last", int'(u_if.last_slice), el);
      end
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (u_if.frame_done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) check("done_timeout", 0, 1);
      exp_done++;
      tick();
      check("idle_busy", int'(u_if.frame_busy), 0);
      check("idle_valid", int'(u_if.ray_valid), 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_valid", int'(u_if.ray_valid), 0);
      check("rst_slice", int'(u_if.slice_index), 0);
      check("rst_int", int'(u_if.ray_angle_int), 0);
      check("rst_frac", int'(u_if.ray_angle_frac), 0);
      check("rst_last", int'(u_if.last_slice), 0);
      check("rst_busy", int'(u_if.frame_busy), 0);
      check("rst_done", int'(u_if.frame_done), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      clk               = 1'b0;
      reset             = 1'b1;
      checks            = 0;
      errors            = 0;
      n_done            = 0;
      exp_done          = 0;
      pend_done         = 1'b0;
      u_if.frame_start  = 1'b0;
      u_if.player_angle = '0;
      u_if.ray_ready    = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check_reset_outputs();

      // Nominal frame
      start_frame(90, 60, 0);
      spot(1, 60, 3, 0);
      spot(159, 119, 5, 1);
      wait_done();

      // Wrap-around, plus a frame_start coinciding with the last transfer
      start_frame(10, 340, 0);
      spot(53, 359, 7, 0);
      spot(54, 0, 2, 0);
      spot(159, 39, 5, 1);
      u_if.frame_start = 1'b1;
      tick();
      u_if.frame_start = 1'b0;
      check("last_edge_done", int'(u_if.frame_done), 1);
      exp_done++;
      tick();
      check("last_edge_ignored_busy", int'(u_if.frame_busy), 0);
      tick();
      check("last_edge_ignored_valid", int'(u_if.ray_valid), 0);

      // Backpressure at slice 7
      start_frame(90, 60, 0);
      wait_slice(7, ok);
      u_if.ray_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", int'(u_if.ray_valid), 1);
         check("bp_slice", int'(u_if.slice_index), 7);
         check("bp_int", int'(u_if.ray_angle_int), 62);
         check("bp_frac", int'(u_if.ray_angle_frac), 5);
      end
      u_if.ray_ready = 1'b1;
      wait_done();

      // Mid-frame request and heading change are ignored
      start_frame(90, 60, 0);
      wait_slice(20, ok);
      u_if.frame_start  = 1'b1;
      u_if.player_angle = 9'd200;
      tick();
      u_if.frame_start  = 1'b0;
      spot(159, 119, 5, 1);
      wait_done();
      start_frame(200, 170, 0);
      wait_done();

      // Reset mid-frame
      start_frame(90, 60, 0);
      wait_slice(80, ok);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q.delete();
      check_reset_outputs();
      start_frame(0, 330, 0);
      wait_done();

      // Out-of-range heading
      start_frame(400, 10, 0);
      spot(159, 69, 5, 1);
      wait_done();

      tick();
      check("sb_empty", q.size(), 0);
      check("done_count", n_done, exp_done);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ray_slice_sequencer.md
# ray_slice_sequencer

Per-frame ray sequencer for the raycaster: on a frame start it walks screen columns 0..SLICES-1 and emits one ray angle per column. Each angle is the player heading minus half the field of view, plus slice × 0.375°, wrapped into [0°, 360°). It sits directly upstream of the slice-angle fixed-point stage and the ray caster, and feeds them over a valid/ready handshake. Angles are produced incrementally by an accumulator in eighths of a degree, with no multiplier.

## Interface
- SLICES, 160, columns per frame (slice_index width 8 bits; SLICES ≤ 256)
- HALF_FOV_EIGHTHS, 240, half field of view in 1/8° (30°)
- STEP_EIGHTHS, 3, per-slice angle increment in 1/8° (0.375°)
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  single-cycle request to begin a frame; honoured only in IDLE
- player_angle  in  9  player heading in integer degrees, latched on an accepted frame_start
- ray_ready  in  1  downstream can accept the current ray
- ray_valid  out  1  slice_index/ray_angle_* hold a valid ray
- slice_index  out  8  column number of the current ray, 0..SLICES-1
- ray_angle_int  out  9  integer degrees of the ray angle, 0..359
- ray_angle_frac  out  3  fractional eighths of a degree, 0..7
- last_slice  out  1  high with ray_valid when slice_index == SLICES-1
- frame_busy  out  1  high in EMIT and DONE
- frame_done  out  1  one-cycle pulse after the last ray transfers

## Operation
- States are IDLE, EMIT and DONE. Reset state is IDLE.
- IDLE → EMIT on frame_start. The following are loaded on the same edge:
  - slice_index ← 0
  - acc (12-bit, units of 1/8°) ← wrap(a×8 − HALF_FOV_EIGHTHS)
  - a = player_angle if player_angle < 360, else player_angle − 360
  - wrap adds 2880 if the result is negative.
- EMIT behaviour:
  - ray_valid = 1, ray_angle_int = acc[11:3], ray_angle_frac = acc[2:0].
  - A transfer occurs when ray_valid && ray_ready are both high on an edge.
  - On a transfer that is not the last slice: slice_index += 1; acc += STEP_EIGHTHS, minus 2880 if the sum ≥ 2880. acc is always in 0..2879.
  - On a transfer when last_slice is high: go to DONE.
  - Without a transfer, all outputs hold exactly.
- DONE: ray_valid = 0, frame_done = 1 for exactly one cycle, then IDLE.
- frame_start in EMIT or DONE is ignored and not queued. Changes to player_angle mid-frame have no effect.
- Reset outputs: ray_valid 0, slice_index 0, ray_angle_int 0, ray_angle_frac 0, last_slice 0, frame_busy 0, frame_done 0.

## Timing
- Latency: frame_start sampled at edge N → ray_valid high after edge N (first ray visible in cycle N+1).
- With ray_ready held high, one ray per cycle: SLICES transfers on consecutive edges N+1..N+SLICES. frame_done is high in the cycle after the last transfer. IDLE is reached one cycle later, so the next frame_start can be accepted at edge N+SLICES+2.
- ray_valid never drops mid-frame without reset, and outputs are stable while ray_valid && !ray_ready.
- reset high on any edge overrides everything, including a simultaneous frame_start or transfer. State returns to IDLE with reset output values after that edge.
- If the last transfer happens on the same edge as a frame_start, the frame_start is ignored.

## Test plan
- Nominal frame: player_angle=90, ray_ready=1, pulse frame_start → 160 consecutive rays.
  - slice 0 = 60/0, slice 1 = 60/3, slice 159 = 119/5 with last_slice=1.
  - frame_done pulses once, one cycle after the last ray.
- Wrap-around: player_angle=10 → slice 0 = 340/0, slice 53 = 359/7, slice 54 = 0/2, slice 159 = 39/5.
- Backpressure: player_angle=90, ray_ready low for 5 cycles while slice_index=7.
  - slice_index=7 and angle 62/5 are held stable.
  - No slice is skipped or duplicated; 160 transfers total.
- Ignored requests: mid-frame, pulse frame_start and change player_angle to 200 → sequence unchanged.
  - A frame_start after returning to IDLE starts a new frame with slice 0 = 170/0.
- Reset mid-frame: assert reset when slice_index=80.
  - The next cycle shows all outputs at reset values.
  - A new frame_start with player_angle=0 gives slice 0 = 330/0.
- Out-of-range heading: player_angle=400 is treated as 40 → slice 0 = 10/0, slice 159 = 69/5.
